// File: rtl/sum_bcd_fsm.sv
// sum_bcd_fsm
//    Adds a 4-bit operand to a running sum on each rising edge of `add`.
//    The sum saturates at MAX_SUM. A shift-add-3 (double-dabble) sequence
//    then converts the sum into three BCD digits for 7-segment decoders.
//
// Ports
//    clk            system clock, rising edge active
//    rst            asynchronous active-low reset
//    data_in[3:0]   unsigned operand (0..15, added as-is)
//    add            level input; only its rising edge starts a sequence
//    clear          synchronous clear of sum, digits and overflow (priority)
//    ones_digit     BCD units   (registered)
//    tens_digit     BCD tens    (registered)
//    hundreds_digit BCD hundreds (registered)
//    busy           high while ADD/CONV/DONE are in progress (registered)
//    overflow       sticky saturation flag (registered)
module sum_bcd_fsm #(
   parameter int MAX_SUM = 999,
   parameter int SUM_W   = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] data_in,
   input  logic       add,
   input  logic       clear,
   output logic [3:0] ones_digit,
   output logic [3:0] tens_digit,
   output logic [3:0] hundreds_digit,
   output logic       busy,
   output logic       overflow
);

   // Shift register holds the 12-bit BCD field above the binary field.
   localparam int SH_W = SUM_W + 12;
   localparam int IT_W = $clog2(SUM_W + 1);
   localparam logic [SUM_W:0]  MAX_EXT  = (SUM_W + 1)'(MAX_SUM);
   localparam logic [IT_W-1:0] LAST_IT  = IT_W'(SUM_W - 1);
   localparam logic [IT_W-1:0] ONE_IT   = IT_W'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      CONV = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t            state_r, state_s;
   logic [SUM_W-1:0]  sum_r, sum_s;
   logic [3:0]        op_r, op_s;
   logic [SH_W-1:0]   shift_r, shift_s;
   logic [IT_W-1:0]   iter_r, iter_s;
   logic              add_q_r;
   logic [3:0]        ones_r, ones_s;
   logic [3:0]        tens_r, tens_s;
   logic [3:0]        hund_r, hund_s;
   logic              busy_r, busy_s;
   logic              ovf_r, ovf_s;
   logic              add_rise_s;
   logic [SUM_W:0]    raw_s;

   // One double-dabble iteration: correct every BCD nibble >= 5, then shift.
   function automatic logic [SH_W-1:0] dabble_step(input logic [SH_W-1:0] v);
      logic [SH_W-1:0] t;
      t = v;
      for (int d = 0; d < 3; d++) begin
         t[SUM_W + 4*d +: 4] = (t[SUM_W + 4*d +: 4] >= 4'd5) ?
                               (t[SUM_W + 4*d +: 4] + 4'd3) :
                               t[SUM_W + 4*d +: 4];
      end
      return {t[SH_W-2:0], 1'b0};
   endfunction

   assign add_rise_s = add & ~add_q_r;
   // One extra bit so the raw sum above MAX_SUM is visible before clamping.
   assign raw_s      = {1'b0, sum_r} + {{(SUM_W - 3){1'b0}}, op_r};

   // Next-state and datapath logic; clear overrides every state.
   always_comb begin
      state_s = state_r;
      sum_s   = sum_r;
      op_s    = op_r;
      shift_s = shift_r;
      iter_s  = iter_r;
      ones_s  = ones_r;
      tens_s  = tens_r;
      hund_s  = hund_r;
      ovf_s   = ovf_r;
      busy_s  = 1'b0;

      if (clear) begin
         state_s = IDLE;
         sum_s   = {SUM_W{1'b0}};
         ones_s  = 4'd0;
         tens_s  = 4'd0;
         hund_s  = 4'd0;
         ovf_s   = 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (add_rise_s) begin
                  op_s    = data_in;
                  state_s = ADD;
               end else begin
                  state_s = IDLE;
               end
            end
            ADD: begin
               if (raw_s > MAX_EXT) begin
                  sum_s = MAX_EXT[SUM_W-1:0];
                  ovf_s = 1'b1;
               end else begin
                  sum_s = raw_s[SUM_W-1:0];
               end
               shift_s = {12'd0, sum_s};
               iter_s  = {IT_W{1'b0}};
               state_s = CONV;
            end
            CONV: begin
               shift_s = dabble_step(shift_r);
               iter_s  = iter_r + ONE_IT;
               if (iter_r == LAST_IT) begin
                  state_s = DONE;
               end else begin
                  state_s = CONV;
               end
            end
            DONE: begin
               hund_s  = shift_r[SUM_W + 8 +: 4];
               tens_s  = shift_r[SUM_W + 4 +: 4];
               ones_s  = shift_r[SUM_W +: 4];
               state_s = IDLE;
            end
            default: begin
               state_s = IDLE;
            end
         endcase
      end

      busy_s = (state_s != IDLE);
   end

   // State and datapath registers. add_q resets high so an add held
   // through reset release is not mistaken for a new request.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= IDLE;
         sum_r   <= {SUM_W{1'b0}};
         op_r    <= 4'd0;
         shift_r <= {SH_W{1'b0}};
         iter_r  <= {IT_W{1'b0}};
         add_q_r <= 1'b1;
         ones_r  <= 4'd0;
         tens_r  <= 4'd0;
         hund_r  <= 4'd0;
         busy_r  <= 1'b0;
         ovf_r   <= 1'b0;
      end else begin
         state_r <= state_s;
         sum_r   <= sum_s;
         op_r    <= op_s;
         shift_r <= shift_s;
         iter_r  <= iter_s;
         add_q_r <= add;
         ones_r  <= ones_s;
         tens_r  <= tens_s;
         hund_r  <= hund_s;
         busy_r  <= busy_s;
         ovf_r   <= ovf_s;
      end
   end

   assign ones_digit     = ones_r;
   assign tens_digit     = tens_r;
   assign hundreds_digit = hund_r;
   assign busy           = busy_r;
   assign overflow       = ovf_r;

endmodule

// File: tb/tb_sum_bcd_fsm.sv
// tb_sum_bcd_fsm
//    Directed bench for sum_bcd_fsm. Digits are compared as a packed
//    {hundreds, tens, ones} value, written in hex so it reads as decimal.
module tb_sum_bcd_fsm;

   logic       clk;
   logic       rst;
   logic [3:0] data_in;
   logic       add;
   logic       clear;
   logic [3:0] ones_digit;
   logic [3:0] tens_digit;
   logic [3:0] hundreds_digit;
   logic       busy;
   logic       overflow;
   logic [11:0] digits;

   int n_checks;
   int n_fail;

   sum_bcd_fsm #(.MAX_SUM(999), .SUM_W(10)) dut (
      .clk            (clk),
      .rst            (rst),
      .data_in        (data_in),
      .add            (add),
      .clear          (clear),
      .ones_digit     (ones_digit),
      .tens_digit     (tens_digit),
      .hundreds_digit (hundreds_digit),
      .busy           (busy),
      .overflow       (overflow)
   );

   assign digits = {hundreds_digit, tens_digit, ones_digit};

   // Free-running clock, 10 time-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_val(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Pulse add with operand v, then wait (bounded) for busy to fall.
   // snap holds the digits seen on the last busy cycle.
   task automatic do_add(input logic [3:0] v, output logic [11:0] snap);
      int cyc;
      @(negedge clk);
      data_in = v;
      add     = 1'b1;
      @(negedge clk);
      add  = 1'b0;
      cyc  = 0;
      snap = digits;
      while (busy && cyc < 40) begin
         cyc++;
         snap = digits;
         @(negedge clk);
      end
      check_val("busy_len", cyc, 12);
   endtask

   task automatic do_clear();
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
   endtask

   initial begin
      logic [11:0] snap;
      int cyc;
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      data_in  = 4'd0;
      add      = 1'b0;
      clear    = 1'b0;

      // Reset asserted before the first clock edge.
      #1 rst = 1'b0;
      #1;
      check_val("rst_digits", digits, 12'h000);
      check_val("rst_busy", busy, 1'b0);
      check_val("rst_ovf", overflow, 1'b0);
      repeat (2) @(negedge clk);
      #1 rst = 1'b1;

      // First add of 7.
      do_add(4'd7, snap);
      check_val("add7_digits", digits, 12'h007);
      check_val("add7_ovf", overflow, 1'b0);

      // Build to 95 (7 + 5*15 + 13), operands above 9 included.
      for (int i = 0; i < 5; i++) do_add(4'd15, snap);
      do_add(4'd13, snap);
      check_val("sum95", digits, 12'h095);

      // 95 + 8: old digits right up to E12, then 103.
      do_add(4'd8, snap);
      check_val("pre_e12_digits", snap, 12'h095);
      check_val("sum103", digits, 12'h103);

      // add held high for 30 cycles counts once.
      do_clear();
      check_val("clear_digits", digits, 12'h000);
      @(negedge clk);
      data_in = 4'd5;
      add     = 1'b1;
      cyc     = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (busy) cyc++;
      end
      add = 1'b0;
      check_val("held_busy_len", cyc, 12);
      check_val("held_sum5", digits, 12'h005);

      // Second pulse at E5 while busy is ignored.
      do_clear();
      @(negedge clk);
      data_in = 4'd5;
      add     = 1'b1;
      @(negedge clk);
      add = 1'b0;
      repeat (4) @(negedge clk);
      data_in = 4'd9;
      add     = 1'b1;
      @(negedge clk);
      add = 1'b0;
      cyc = 0;
      while (busy && cyc < 40) begin
         cyc++;
         @(negedge clk);
      end
      check_val("busy_pulse_end", busy, 1'b0);
      repeat (3) @(negedge clk);
      check_val("ignored_busy", busy, 1'b0);
      check_val("ignored_sum5", digits, 12'h005);

      // Preload 995 = 66*15 + 5, then saturate.
      do_clear();
      for (int i = 0; i < 66; i++) do_add(4'd15, snap);
      do_add(4'd5, snap);
      check_val("sum995", digits, 12'h995);
      check_val("ovf_995", overflow, 1'b0);
      do_add(4'd15, snap);
      check_val("sat_digits", digits, 12'h999);
      check_val("sat_ovf", overflow, 1'b1);
      do_add(4'd1, snap);
      check_val("sat2_digits", digits, 12'h999);
      check_val("sat2_ovf", overflow, 1'b1);

      // Clear sampled at E6 mid-conversion.
      @(negedge clk);
      data_in = 4'd3;
      add     = 1'b1;
      @(negedge clk);
      add = 1'b0;
      repeat (5) @(negedge clk);
      check_val("mid_busy", busy, 1'b1);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      check_val("clr_digits", digits, 12'h000);
      check_val("clr_busy", busy, 1'b0);
      check_val("clr_ovf", overflow, 1'b0);
      do_add(4'd4, snap);
      check_val("after_clr_sum4", digits, 12'h004);

      // Asynchronous reset mid-CONV with add held through release.
      @(negedge clk);
      data_in = 4'd2;
      add     = 1'b1;
      @(negedge clk);
      add = 1'b0;
      repeat (4) @(negedge clk);
      add = 1'b1;
      #1 rst = 1'b0;
      #1;
      check_val("arst_digits", digits, 12'h000);
      check_val("arst_busy", busy, 1'b0);
      @(negedge clk);
      #1 rst = 1'b1;
      cyc = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (busy) cyc++;
      end
      add = 1'b0;
      check_val("no_spurious_add", cyc, 0);
      check_val("post_rst_digits", digits, 12'h000);
      do_add(4'd6, snap);
      check_val("post_rst_sum6", digits, 12'h006);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
